// File: rtl/psd_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : psd_stream_packer
// Purpose  : N-source round-robin event framer. The winning source's event is
//            wrapped as {header, data words, trailer} on a registered
//            valid/ready/last stream towards the streaming FIFO.
// Ports    : mclk, mrst        - clock, synchronous active-high reset
//            board_id          - board identifier placed in the header
//            src_valid/last    - per-source word valid / last word of event
//            src_tag/src_data  - per-source packed tag and payload buses
//            src_ready         - per-source word accepted
//            fifo_data/tvalid/tlast/tready - output stream
//            event_count       - completed packets (wraps at 16 bits)
//            busy              - framer active or a word still on the stream
// Revision : 1.0 - initial release
// ============================================================================
module psd_stream_packer #(
  parameter int               NUM_SRC   = 4,
  parameter int               DATA_W    = 24,
  parameter int               TAG_W     = 8,
  parameter int               MAX_WORDS = 16,
  parameter logic [TAG_W-1:0] HDR_TAG   = 8'hA5,
  parameter logic [TAG_W-1:0] TRL_TAG   = 8'h5A
) (
  input  logic                        mclk,
  input  logic                        mrst,
  input  logic [7:0]                  board_id,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC-1:0]          src_last,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [TAG_W+DATA_W-1:0]     fifo_data,
  output logic                        tvalid,
  input  logic                        tready,
  output logic                        tlast,
  output logic [15:0]                 event_count,
  output logic                        busy
);

  localparam int GW    = $clog2(NUM_SRC);
  localparam int OUT_W = TAG_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_DATA    = 3'd2,
    S_DRAIN   = 3'd3,
    S_TRAILER = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      r_rr_ptr;
  logic [7:0]         r_word_cnt;
  logic               r_trunc;
  logic [OUT_W-1:0]   r_fifo_data;
  logic               r_tvalid;
  logic               r_tlast;
  logic [15:0]        r_event_count;

  logic               w_can_load;
  logic               w_trl_hs;
  logic [15:0]        w_hdr_count;
  logic [GW-1:0]      w_rr_grant;
  logic [GW:0]        w_scan;
  logic [NUM_SRC-1:0] w_grant_oh;
  logic               w_g_valid;
  logic               w_g_last;
  logic [TAG_W-1:0]   w_g_tag;
  logic [DATA_W-1:0]  w_g_data;
  logic               w_load_hdr;
  logic               w_load_data;
  logic               w_load_trl;
  logic               w_set_trunc;
  logic [OUT_W-1:0]   w_word;

  assign w_can_load = !r_tvalid || tready;
  assign w_trl_hs   = r_tvalid && tready && r_tlast;

  // A header loaded in the same cycle the previous trailer is accepted must
  // already show the incremented count.
  assign w_hdr_count = r_event_count + {15'd0, w_trl_hs};

  // Round-robin search: first requesting source at or after r_rr_ptr.
  // Scanning from the far end lets the nearest requester win.
  always_comb begin
    w_rr_grant = '0;
    w_scan     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_scan = {1'b0, r_rr_ptr} + (GW+1)'(k);
      if (w_scan >= (GW+1)'(NUM_SRC)) begin
        w_scan = w_scan - (GW+1)'(NUM_SRC);
      end
      if (src_valid[w_scan[GW-1:0]]) begin
        w_rr_grant = w_scan[GW-1:0];
      end
    end
  end

  // Granted-source view of the packed input buses.
  always_comb begin
    w_grant_oh = '0;
    w_g_valid  = 1'b0;
    w_g_last   = 1'b0;
    w_g_tag    = '0;
    w_g_data   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant == GW'(i)) begin
        w_grant_oh[i] = 1'b1;
        w_g_valid     = src_valid[i];
        w_g_last      = src_last[i];
        w_g_tag       = src_tag[i*TAG_W +: TAG_W];
        w_g_data      = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, load strobes and src_ready.
  always_comb begin
    w_state_nxt = r_state;
    src_ready   = '0;
    w_load_hdr  = 1'b0;
    w_load_data = 1'b0;
    w_load_trl  = 1'b0;
    w_set_trunc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|src_valid) w_state_nxt = S_HEADER;
      end
      S_HEADER: begin
        if (w_can_load) begin
          w_load_hdr  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        // Backpressure reaches the source in the same cycle.
        src_ready = w_grant_oh & {NUM_SRC{w_can_load}};
        if (w_g_valid && w_can_load) begin
          w_load_data = 1'b1;
          if (w_g_last) begin
            w_state_nxt = S_TRAILER;
          end else if (({1'b0, r_word_cnt} + 9'd1) == 9'(MAX_WORDS)) begin
            w_set_trunc = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Remainder of an oversize event is swallowed without output.
        src_ready = w_grant_oh;
        if (w_g_valid && w_g_last) w_state_nxt = S_TRAILER;
      end
      S_TRAILER: begin
        if (w_can_load) begin
          w_load_trl  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_word = '0;
    if (w_load_hdr) begin
      w_word = {HDR_TAG, DATA_W'({board_id, w_hdr_count})};
    end else if (w_load_data) begin
      w_word = {w_g_tag, w_g_data};
    end else if (w_load_trl) begin
      w_word = {TRL_TAG, DATA_W'({7'd0, r_trunc, r_word_cnt})};
    end
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_word_cnt    <= '0;
      r_trunc       <= 1'b0;
      r_fifo_data   <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_event_count <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE && (|src_valid)) begin
        r_grant    <= w_rr_grant;
        r_word_cnt <= '0;
        r_trunc    <= 1'b0;
      end
      if (w_load_data) r_word_cnt <= r_word_cnt + 8'd1;
      if (w_set_trunc) r_trunc <= 1'b1;
      if (w_load_trl) begin
        r_rr_ptr <= (r_grant == GW'(NUM_SRC - 1)) ? '0 : r_grant + GW'(1);
      end

      if (w_trl_hs) r_event_count <= r_event_count + 16'd1;

      if (w_load_hdr || w_load_data || w_load_trl) begin
        r_fifo_data <= w_word;
        r_tvalid    <= 1'b1;
        r_tlast     <= w_load_trl;
      end else if (tready) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign fifo_data   = r_fifo_data;
  assign tvalid      = r_tvalid;
  assign tlast       = r_tlast;
  assign event_count = r_event_count;
  assign busy        = (r_state != S_IDLE) || r_tvalid;

endmodule
`default_nettype wire
